// File: rtl/quad_job_sequencer.sv
// Job-descriptor FIFO feeding a single quad through a start / fetch / run / done handshake FSM,
// with a per-state timeout that parks the block in ERROR until soft_clr.
module quad_job_sequencer #(
    parameter int C_FIFO_DEPTH = 4,
    parameter int C_TIMEOUT    = 65535
) (
    input  logic         clk_if,
    input  logic         rst,
    input  logic         host_job_valid,
    output logic         host_job_ready,
    input  logic [127:0] host_job_params,
    output logic         job_start,
    output logic [127:0] job_parameters,
    output logic         job_parameters_valid,
    input  logic         job_accept,
    input  logic         job_fetch_request,
    output logic         job_fetch_ack,
    output logic         job_fetch_complete,
    output logic         dma_start,
    input  logic         dma_done,
    input  logic         job_complete,
    output logic         job_complete_ack,
    input  logic         soft_clr,
    output logic         busy,
    output logic         err,
    output logic [15:0]  jobs_done
);

    localparam int AW = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
    localparam int TW = $clog2(C_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_FETCH_REQ, S_FETCH_WAIT, S_RUN, S_DONE, S_ERROR
    } state_t;

    logic [127:0]  fifo_mem [C_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop, fifo_full, fifo_empty;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          timeout, counting;
    logic [1:0]    sync_q;

    logic          start_q, start_d;
    logic [127:0]  params_q, params_d;
    logic          fetch_ack_q, fetch_ack_d;
    logic          fetch_complete_q, fetch_complete_d;
    logic          dma_start_q, dma_start_d;
    logic          complete_ack_q, complete_ack_d;
    logic          err_q, err_d;
    logic [15:0]   jobs_done_q, jobs_done_d;

    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    assign fifo_full      = (count_q == (AW+1)'(C_FIFO_DEPTH));
    assign fifo_empty     = (count_q == '0);
    assign pop            = (state_q == S_START) && job_accept;
    assign host_job_ready = !fifo_full || pop;
    assign push           = host_job_valid && host_job_ready;

    assign counting = (state_q == S_START) || (state_q == S_FETCH_REQ) ||
                      (state_q == S_FETCH_WAIT) || (state_q == S_RUN);
    assign timeout  = counting && (timer_q == TW'(C_TIMEOUT - 1));

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        fetch_ack_d      = 1'b0;
        dma_start_d      = 1'b0;
        fetch_complete_d = 1'b0;
        complete_ack_d   = 1'b0;
        err_d            = err_q && !soft_clr;
        jobs_done_d      = jobs_done_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && sync_q[1]) state_d = S_START;
            end
            S_START: begin
                if (job_accept)   state_d = S_FETCH_REQ;
                else if (timeout) state_d = S_ERROR;
            end
            S_FETCH_REQ: begin
                if (job_fetch_request) begin
                    fetch_ack_d = 1'b1;
                    dma_start_d = 1'b1;
                    state_d     = S_FETCH_WAIT;
                end else if (timeout) begin
                    state_d = S_ERROR;
                end
            end
            S_FETCH_WAIT: begin
                if (dma_done) begin
                    fetch_complete_d = 1'b1;
                    state_d          = S_RUN;
                end else if (timeout) begin
                    state_d = S_ERROR;
                end
            end
            // Completion takes priority over a simultaneous extra fetch request.
            S_RUN: begin
                if (job_complete) begin
                    complete_ack_d = 1'b1;
                    state_d        = S_DONE;
                end else if (job_fetch_request) begin
                    fetch_ack_d = 1'b1;
                    dma_start_d = 1'b1;
                    state_d     = S_FETCH_WAIT;
                end else if (timeout) begin
                    state_d = S_ERROR;
                end
            end
            S_DONE: begin
                jobs_done_d = jobs_done_q + 16'd1;
                state_d     = S_IDLE;
            end
            S_ERROR: begin
                if (soft_clr) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_ERROR && state_q != S_ERROR) err_d = 1'b1;

        start_d  = (state_d == S_START);
        params_d = start_d ? fifo_mem[rd_ptr_q] : '0;

        if (state_d != state_q) timer_d = '0;
        else if (counting)      timer_d = timer_q + TW'(1);
        else                    timer_d = '0;
    end

    always_ff @(posedge clk_if) begin
        if (push) fifo_mem[wr_ptr_q] <= host_job_params;
    end

    // Reset asserts asynchronously; sync_q gates the first IDLE exit until release is clock-aligned.
    always_ff @(posedge clk_if or negedge rst) begin
        if (!rst) begin
            sync_q           <= 2'b00;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            state_q          <= S_IDLE;
            timer_q          <= '0;
            start_q          <= 1'b0;
            params_q         <= '0;
            fetch_ack_q      <= 1'b0;
            fetch_complete_q <= 1'b0;
            dma_start_q      <= 1'b0;
            complete_ack_q   <= 1'b0;
            err_q            <= 1'b0;
            jobs_done_q      <= '0;
        end else begin
            sync_q           <= {sync_q[0], 1'b1};
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            state_q          <= state_d;
            timer_q          <= timer_d;
            start_q          <= start_d;
            params_q         <= params_d;
            fetch_ack_q      <= fetch_ack_d;
            fetch_complete_q <= fetch_complete_d;
            dma_start_q      <= dma_start_d;
            complete_ack_q   <= complete_ack_d;
            err_q            <= err_d;
            jobs_done_q      <= jobs_done_d;
        end
    end

    assign job_start            = start_q;
    assign job_parameters_valid = start_q;
    assign job_parameters       = params_q;
    assign job_fetch_ack        = fetch_ack_q;
    assign job_fetch_complete   = fetch_complete_q;
    assign dma_start            = dma_start_q;
    assign job_complete_ack     = complete_ack_q;
    assign err                  = err_q;
    assign jobs_done            = jobs_done_q;
    assign busy                 = (state_q != S_IDLE);

endmodule

// File: tb/tb_quad_job_sequencer.sv
// Bench for quad_job_sequencer: descriptor scoreboard, table of job shapes, and hand-written
// sequences for FIFO full, timeout/soft_clr and reset in the middle of a job.
module tb_quad_job_sequencer;

    logic         clk_if = 1'b0;
    logic         rst;
    logic         host_job_valid, host_job_ready;
    logic [127:0] host_job_params;
    logic         job_start, job_parameters_valid, job_accept;
    logic [127:0] job_parameters;
    logic         job_fetch_request, job_fetch_ack, job_fetch_complete;
    logic         dma_start, dma_done, job_complete, job_complete_ack, soft_clr;
    logic         busy, err;
    logic [15:0]  jobs_done;

    int n_checks = 0;
    int n_pass   = 0;
    logic [127:0] sb_q [$];

    typedef struct {
        logic [127:0] params;
        int           acc_dly;
        int           nfetch;
        bit           both;
        logic [15:0]  exp_done;
    } vec_t;
    vec_t tbl [4];

    always #5 clk_if = ~clk_if;

    quad_job_sequencer #(.C_FIFO_DEPTH(4), .C_TIMEOUT(16)) dut (
        .clk_if(clk_if), .rst(rst),
        .host_job_valid(host_job_valid), .host_job_ready(host_job_ready),
        .host_job_params(host_job_params),
        .job_start(job_start), .job_parameters(job_parameters),
        .job_parameters_valid(job_parameters_valid), .job_accept(job_accept),
        .job_fetch_request(job_fetch_request), .job_fetch_ack(job_fetch_ack),
        .job_fetch_complete(job_fetch_complete),
        .dma_start(dma_start), .dma_done(dma_done),
        .job_complete(job_complete), .job_complete_ack(job_complete_ack),
        .soft_clr(soft_clr), .busy(busy), .err(err), .jobs_done(jobs_done)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic step();
        @(posedge clk_if);
        #1;
    endtask

    task automatic push_job(input logic [127:0] p);
        int k = 0;
        host_job_valid  = 1'b1;
        host_job_params = p;
        while (!host_job_ready && k < 50) begin step(); k++; end
        check("push_ready", host_job_ready, 1);
        step();
        host_job_valid = 1'b0;
        sb_q.push_back(p);
    endtask

    task automatic wait_start();
        int k = 0;
        while (!job_start && k < 50) begin step(); k++; end
        check("start_seen", job_start, 1);
    endtask

    task automatic start_job(input int acc_dly);
        logic [127:0] exp_p;
        wait_start();
        exp_p = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        check("job_params", job_parameters, exp_p);
        check("params_valid", job_parameters_valid, 1);
        repeat (acc_dly) step();
        check("params_held", {job_start, job_parameters}, {1'b1, exp_p});
        job_accept = 1'b1;
        step();
        job_accept = 1'b0;
        check("start_dropped", {job_start, job_parameters_valid}, 0);
        check("params_cleared", job_parameters, 0);
    endtask

    task automatic do_fetch();
        job_fetch_request = 1'b1;
        step();
        job_fetch_request = 1'b0;
        check("fetch_ack", job_fetch_ack, 1);
        check("dma_start", dma_start, 1);
        step();
        check("fetch_ack_pulse", {job_fetch_ack, dma_start}, 0);
        step();
        dma_done = 1'b1;
        step();
        dma_done = 1'b0;
        check("fetch_complete", job_fetch_complete, 1);
        step();
        check("fetch_complete_pulse", job_fetch_complete, 0);
    endtask

    task automatic finish_job(input int nfetch, input bit both);
        for (int f = 0; f < nfetch; f++) do_fetch();
        job_complete      = 1'b1;
        job_fetch_request = both;
        step();
        job_complete      = 1'b0;
        job_fetch_request = 1'b0;
        check("complete_ack", job_complete_ack, 1);
        check("no_fetch_on_complete", {job_fetch_ack, dma_start}, 0);
        check("busy_in_done", busy, 1);
        step();
        check("complete_ack_pulse", job_complete_ack, 0);
        check("idle_gap", {busy, job_start}, 0);
        if (sb_q.size() > 0) begin
            step();
            check("next_start", job_start, 1);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl[0] = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32A5, 3, 1, 1'b0, 16'd1};
        tbl[1] = '{128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 0, 2, 1'b0, 16'd2};
        tbl[2] = '{128'h5A5A_5A5A_A5A5_A5A5_0F0F_F0F0_1234_5678, 1, 1, 1'b1, 16'd3};
        tbl[3] = '{{128{1'b1}},                                   2, 3, 1'b0, 16'd4};

        rst = 1'b0;
        host_job_valid = 1'b0; host_job_params = '0; job_accept = 1'b0;
        job_fetch_request = 1'b0; dma_done = 1'b0; job_complete = 1'b0; soft_clr = 1'b0;
        repeat (3) step();
        check("rst_ready", host_job_ready, 1);
        check("rst_busy_err", {busy, err}, 0);
        check("rst_jobs_done", jobs_done, 0);
        check("rst_outputs", {job_start, job_parameters_valid, job_fetch_ack,
                              job_fetch_complete, dma_start, job_complete_ack}, 0);
        check("rst_params", job_parameters, 0);
        rst = 1'b1;
        repeat (3) step();

        // Stray accept / dma_done while idle must do nothing.
        job_accept = 1'b1; dma_done = 1'b1;
        step(); step();
        job_accept = 1'b0; dma_done = 1'b0;
        check("stray_ignored", {busy, job_fetch_complete, job_start}, 0);

        for (int i = 0; i < 4; i++) begin
            push_job(tbl[i].params);
            start_job(tbl[i].acc_dly);
            finish_job(tbl[i].nfetch, tbl[i].both);
            check("jobs_done_tbl", jobs_done, tbl[i].exp_done);
        end

        // FIFO full with the quad stalled, then pop, then push/pop together on full.
        push_job(128'h1);
        push_job(128'h2);
        push_job(128'h3);
        push_job(128'h4);
        check("full_ready_low", host_job_ready, 0);
        host_job_valid = 1'b1; host_job_params = 128'hBAD;
        step(); step();
        host_job_valid = 1'b0;
        check("full_still_blocked", host_job_ready, 0);
        start_job(1);
        check("ready_after_accept", host_job_ready, 1);
        push_job(128'h5);
        finish_job(1, 1'b0);
        check("jobs_done_5", jobs_done, 5);
        wait_start();
        check("full_before_pop", host_job_ready, 0);
        check("job_params", job_parameters, sb_q.pop_front());
        job_accept = 1'b1; host_job_valid = 1'b1; host_job_params = 128'h6;
        #1;
        check("ready_on_pop_full", host_job_ready, 1);
        step();
        job_accept = 1'b0; host_job_valid = 1'b0;
        sb_q.push_back(128'h6);
        check("start_dropped", job_start, 0);
        finish_job(1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            start_job(0);
            finish_job(1, 1'b0);
        end
        check("jobs_done_10", jobs_done, 10);

        // Timeout in FETCH_WAIT, then soft_clr releases the next queued job.
        push_job(128'h7001);
        push_job(128'h7002);
        start_job(0);
        job_fetch_request = 1'b1;
        step();
        job_fetch_request = 1'b0;
        check("to_fetch_ack", job_fetch_ack, 1);
        repeat (15) step();
        check("to_err_before", err, 0);
        step();
        check("to_err_set", err, 1);
        check("to_outputs_zero", {job_start, job_parameters_valid, job_fetch_ack,
                                  job_fetch_complete, dma_start, job_complete_ack}, 0);
        check("to_busy", busy, 1);
        dma_done = 1'b1;
        step();
        dma_done = 1'b0;
        check("to_dma_ignored", {job_fetch_complete, err}, 2'b01);
        push_job(128'h7003);
        soft_clr = 1'b1;
        step();
        soft_clr = 1'b0;
        check("clr_err", err, 0);
        check("clr_idle", busy, 0);
        start_job(0);
        finish_job(1, 1'b0);
        start_job(0);
        finish_job(1, 1'b0);
        check("jobs_done_12", jobs_done, 12);

        // Reset asserted while the quad is running a job.
        push_job(128'h8001);
        push_job(128'h8002);
        start_job(0);
        do_fetch();
        rst = 1'b0;
        #1;
        check("mid_rst_jobs_done", jobs_done, 0);
        check("mid_rst_ready", host_job_ready, 1);
        check("mid_rst_status", {busy, err, job_start, job_complete_ack, job_fetch_ack}, 0);
        check("mid_rst_params", job_parameters, 0);
        sb_q.delete();
        step(); step();
        rst = 1'b1;
        repeat (6) step();
        check("post_rst_fifo_empty", {busy, job_start}, 0);
        push_job(128'h9001);
        start_job(0);
        finish_job(1, 1'b0);
        check("post_rst_jobs_done", jobs_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/quad_job_sequencer.md
QUAD_JOB_SEQUENCER -- requirements
Module: quad_job_sequencer

Interface
REQ-001 Parameter: C_FIFO_DEPTH, 4, job-descriptor FIFO depth (power of 2, 2..16).
REQ-002 Parameter: C_TIMEOUT, 65535, wait-state cycle limit before the block enters ERROR.
REQ-003 Port: clk_if  in  1  sole clock; all logic on rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-low reset; the polarity and synchronicity are fixed.
REQ-005 Port: host_job_valid / host_job_ready / host_job_params  in / out / in  1/1/128  descriptor push handshake.
REQ-006 Port: job_start / job_parameters / job_parameters_valid  out  1/128/1  job offer to quad.
REQ-007 Port: job_accept  in  1  quad takes offered job.
REQ-008 Port: job_fetch_request / job_fetch_ack / job_fetch_complete  in / out / out  1 each  quad data-fetch handshake.
REQ-009 Port: dma_start / dma_done  out / in  1 each  external fetch engine control (pulse / pulse).
REQ-010 Port: job_complete / job_complete_ack  in / out  1 each  quad completion handshake.
REQ-011 Port: soft_clr  in  1  clears ERROR and the sticky error flag.
REQ-012 Port: busy / err / jobs_done  out  1/1/16  status: FSM not IDLE, sticky timeout, completed-job count.

Function
REQ-013 FIFO SHALL push on host_job_valid&&host_job_ready; host_job_ready = !full; FIFO SHALL pop only on the job_accept cycle in START.
REQ-014 FSM states SHALL be IDLE, START, FETCH_REQ, FETCH_WAIT, RUN, DONE, ERROR.
REQ-015 IDLE: FIFO non-empty -> START next cycle; else remain.
REQ-016 START: job_start=1, job_parameters_valid=1, job_parameters=FIFO head, all held stable until job_accept=1 is sampled -> pop, deassert next cycle, go FETCH_REQ.
REQ-017 FETCH_REQ: on job_fetch_request=1, job_fetch_ack and dma_start SHALL pulse exactly one cycle (next cycle), then -> FETCH_WAIT.
REQ-018 FETCH_WAIT: on dma_done=1, job_fetch_complete SHALL pulse one cycle, then -> RUN.
REQ-019 RUN: job_complete=1 -> job_complete_ack one-cycle pulse, -> DONE; job_fetch_request=1 (no job_complete) -> FETCH_REQ handling again (multi-fetch jobs); both in same cycle -> job_complete wins, fetch request ignored.
REQ-020 DONE: jobs_done increments by 1 (wraps 0xFFFF->0), -> IDLE next cycle; back-to-back jobs SHALL therefore have exactly one IDLE cycle between DONE and START.
REQ-021 Timeout counter SHALL reset on every state entry and count in START, FETCH_REQ, FETCH_WAIT, RUN; reaching C_TIMEOUT -> ERROR, err=1.
REQ-022 ERROR: all quad/dma outputs 0, FIFO retained, host pushes still accepted; soft_clr=1 -> err=0, state IDLE next cycle; soft_clr outside ERROR only clears err.
REQ-023 dma_done outside FETCH_WAIT and job_accept outside START SHALL be ignored.
REQ-024 FIFO push while full SHALL be blocked (ready=0) and not corrupt contents; simultaneous push and pop on full SHALL succeed.
REQ-025 busy = (state != IDLE); err sticky until soft_clr or reset.

Reset
REQ-026 rst=0 SHALL immediately force state IDLE, FIFO empty, timeout counter 0, jobs_done 0, err 0, all pulse/level outputs 0, job_parameters 0, host_job_ready 1.
REQ-027 Reset mid-job SHALL abandon the job with no completion pulse; release SHALL be synchronized to clk_if before FSM leaves IDLE.

Verification
REQ-028 Single job params=0x...A5 -> START with job_parameters=0x...A5; accept after 3 cycles; fetch req -> ack+dma_start pulse; dma_done -> fetch_complete pulse; job_complete -> ack pulse; jobs_done=1.
REQ-029 Push 5 jobs with depth 4, quad stalled -> host_job_ready=0 after 4; after first accept ready=1; all 5 run in order, jobs_done=5.
REQ-030 Two fetch requests in one job -> two ack/dma_start/fetch_complete sequences, single job_complete_ack.
REQ-031 C_TIMEOUT=16, never assert dma_done -> err=1 after 16 cycles in FETCH_WAIT, outputs 0; soft_clr -> IDLE, next queued job starts.
REQ-032 job_complete and job_fetch_request same RUN cycle -> only job_complete_ack pulses, state DONE.
REQ-033 rst low during RUN -> all outputs 0 immediately, jobs_done=0, FIFO empty, ready=1.
